// File: rtl/cache_controller.sv
// cache_controller: sequencer for a 4-way set-associative cache with
// write-through stores, read-miss fill from backing memory, per-set FIFO
// replacement pointers and saturating hit/miss statistics.
module cache_controller #(
    parameter int NUM_SETS  = 32,
    parameter int NUM_WAYS  = 4,
    parameter int INDEX_LSB = 5,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             cpu_busy,
    output logic             c_read,
    output logic             c_write,
    output logic [31:0]      c_addr,
    output logic [31:0]      c_wdata,
    input  logic [31:0]      c_rdata,
    input  logic             c_hit,
    output logic [WAY_W-1:0] c_replace_way,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]                      state_q, state_d;
    logic                            we_q, we_d;
    logic [31:0]                     addr_q, addr_d;
    logic [31:0]                     wdata_q, wdata_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic                            lk_hit_q, lk_hit_d;
    logic [CNT_W-1:0]                hit_q, hit_d;
    logic [CNT_W-1:0]                miss_q, miss_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]                idx;

    assign idx = addr_q[INDEX_LSB +: IDX_W];

    // Next-state and datapath update for the request sequencer
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        lk_hit_d = lk_hit_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        ptr_d    = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_hit_d = c_hit;
                if (c_hit) hit_d  = (hit_q  == '1) ? hit_q  : hit_q  + CNT_W'(1);
                else       miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
                if (we_q) begin
                    state_d = S_MEM_WR;
                end else if (c_hit) begin
                    rdata_d = c_rdata;
                    state_d = S_RESP;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = S_FILL;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                // Only a miss allocates a new way, so only a miss advances the FIFO
                if (!lk_hit_q)
                    ptr_d[idx] = (ptr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[idx] + WAY_W'(1);
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; async reset aborts any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            lk_hit_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            lk_hit_q <= lk_hit_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            ptr_q    <= ptr_d;
        end
    end

    // Strobes decode straight from state so reset drops them without a clock
    assign cpu_ready     = (state_q == S_RESP);
    assign cpu_busy      = (state_q != S_IDLE);
    assign cpu_rdata     = rdata_q;
    assign c_read        = (state_q == S_LOOKUP);
    assign c_write       = (state_q == S_FILL);
    assign c_addr        = addr_q;
    // On a read fill the fetched word already sits in the load-data register
    assign c_wdata       = we_q ? wdata_q : rdata_q;
    assign c_replace_way = ptr_q[idx];
    assign mem_req       = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_we        = (state_q == S_MEM_WR);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural 4-way cache and memory models,
// directed requests with a scoreboard checked by a separate monitor.
module tb_cache_controller;
    // Narrow counters keep the saturation test short
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]   cpu_addr = '0, cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready, cpu_busy, c_read, c_write, c_hit;
    logic [31:0]   c_addr, c_wdata, c_rdata;
    logic [1:0]    c_replace_way;
    logic          mem_req, mem_we;
    logic [31:0]   mem_addr, mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] hit_count, miss_count;

    cache_controller #(.NUM_SETS(32), .NUM_WAYS(4), .INDEX_LSB(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_hit(c_hit), .c_replace_way(c_replace_way),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- cache model ----------------
    logic        cv   [32][4];
    logic [21:0] ctag [32][4];
    logic [31:0] cdat [32][4];
    logic        cache_clr = 1'b1;
    int          hw;
    int          cw_cnt = 0, cr_cnt = 0, last_fill_way = -1;

    always_comb begin
        c_hit   = 1'b0;
        c_rdata = '0;
        hw      = 0;
        for (int w = 0; w < 4; w++)
            if (cv[c_addr[9:5]][w] && ctag[c_addr[9:5]][w] == c_addr[31:10]) begin
                c_hit   = 1'b1;
                c_rdata = cdat[c_addr[9:5]][w];
                hw      = w;
            end
    end

    always @(posedge clk) begin
        if (c_read) cr_cnt <= cr_cnt + 1;
        if (cache_clr) begin
            for (int s = 0; s < 32; s++)
                for (int w = 0; w < 4; w++) cv[s][w] <= 1'b0;
        end else if (c_write) begin
            cw_cnt <= cw_cnt + 1;
            if (c_hit) begin
                cdat[c_addr[9:5]][hw] <= c_wdata;
            end else begin
                cv  [c_addr[9:5]][c_replace_way] <= 1'b1;
                ctag[c_addr[9:5]][c_replace_way] <= c_addr[31:10];
                cdat[c_addr[9:5]][c_replace_way] <= c_wdata;
                last_fill_way <= int'(c_replace_way);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, errors = 0;
    int mem_delay = 0;
    bit stray_ack = 1'b0;
    int mem_rd_cnt = 0, mem_wr_cnt = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic [31:0] mem_m [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mem_proc();
        int w = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                w = 0;
            end else if (stray_ack) begin
                mem_ack = 1'b1;
                stray_ack = 1'b0;
            end else if (mem_req) begin
                if (w == mem_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_m[mem_addr] = mem_wdata;
                        last_waddr = mem_addr;
                        last_wdata = mem_wdata;
                        mem_wr_cnt++;
                    end else begin
                        mem_rdata = mem_m.exists(mem_addr) ? mem_m[mem_addr]
                                                           : (mem_addr ^ 32'h5A5A_0000);
                        mem_rd_cnt++;
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                    if (e.chk_rd) chk({e.nm, "_rdata"}, cpu_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic chk_rd, input logic [31:0] er, input int lat,
                         input string nm, input bit hold);
        exp_t e;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_busy && n < 200);
        if (cpu_busy) begin
            chk({nm, "_idle_timeout"}, 32'd1, 32'd0);
            return;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        e.chk_rd = chk_rd; e.rdata = er; e.lat = lat; e.acc = cyc + 1; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || cpu_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_timeout"}, 32'(n >= 300), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cache_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; cache_clr = 1'b0;
    endtask

    logic [31:0] rd_addrs [5];
    logic [31:0] rd_vals  [5];
    int cw0, cr0, rd0, n;

    initial begin
        rd_addrs = '{32'h0000_0820, 32'h0000_0C20, 32'h0000_1020, 32'h0000_1420, 32'h0000_1820};
        rd_vals  = '{32'h5A5A_0820, 32'h5A5A_0C20, 32'h5A5A_1020, 32'h5A5A_1420, 32'h5A5A_1820};
        mem_m[32'h0000_0420] = 32'hDEAD_BEEF;
        fork
            mem_proc();
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(cpu_busy),  32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mreq",  32'(mem_req),   32'd0);
        chk("rst_cread", 32'(c_read),    32'd0);
        chk("rst_cwr",   32'(c_write),   32'd0);
        chk("rst_rdata", cpu_rdata,      32'd0);
        chk("rst_hits",  32'(hit_count), 32'd0);
        chk("rst_miss",  32'(miss_count),32'd0);
        chk("rst_way",   32'(c_replace_way), 32'd0);
        reset = 1'b0; cache_clr = 1'b0;

        // 1: read miss, ack 3 cycles late
        mem_delay = 3;
        issue(1'b0, 32'h0000_0420, 32'h0, 1'b1, 32'hDEAD_BEEF, 7, "t1_rd", 1'b0);
        wait_done("t1");
        chk("t1_miss",  32'(miss_count), 32'd1);
        chk("t1_memrd", 32'(mem_rd_cnt), 32'd1);
        chk("t1_fillway", 32'(last_fill_way), 32'd0);
        chk("t1_ptr",   32'(c_replace_way), 32'd1);

        // 2: read hit
        issue(1'b0, 32'h0000_0420, 32'h0, 1'b1, 32'hDEAD_BEEF, 2, "t2_rd", 1'b0);
        wait_done("t2");
        chk("t2_memrd", 32'(mem_rd_cnt), 32'd1);
        chk("t2_hits",  32'(hit_count),  32'd1);

        // 4: write hit goes through to memory, pointer unchanged
        mem_delay = 1;
        issue(1'b1, 32'h0000_0420, 32'h1234_5678, 1'b0, 32'h0, 5, "t4_wr", 1'b0);
        wait_done("t4w");
        chk("t4_memwr", 32'(mem_wr_cnt), 32'd1);
        chk("t4_waddr", last_waddr, 32'h0000_0420);
        chk("t4_wdata", last_wdata, 32'h1234_5678);
        chk("t4_hits",  32'(hit_count), 32'd2);
        chk("t4_ptr",   32'(c_replace_way), 32'd1);
        chk("t4_cwr",   32'(cw_cnt), 32'd2);
        issue(1'b0, 32'h0000_0420, 32'h0, 1'b1, 32'h1234_5678, 2, "t4_rd", 1'b0);
        wait_done("t4r");
        chk("t4_memrd", 32'(mem_rd_cnt), 32'd1);

        // 3: FIFO replacement in set 1
        do_reset();
        chk("t3_rst_hits", 32'(hit_count), 32'd0);
        mem_delay = 0;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, rd_addrs[i], 32'h0, 1'b1, rd_vals[i], 4, "t3_rd", 1'b0);
            wait_done("t3");
            chk("t3_fillway", 32'(last_fill_way), 32'(i % 4));
        end
        rd0 = mem_rd_cnt;
        issue(1'b0, rd_addrs[0], 32'h0, 1'b1, rd_vals[0], 4, "t3_rerd", 1'b0);
        wait_done("t3r");
        chk("t3_rerd_mem", 32'(mem_rd_cnt - rd0), 32'd1);
        chk("t3_rerd_way", 32'(last_fill_way), 32'd1);
        chk("t3_miss", 32'(miss_count), 32'd6);

        // 5: reset during MEM_RD, then a late ack
        do_reset();
        mem_delay = 50;
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h0, 0, "t5_rd", 1'b0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_mreq_seen", 32'(mem_req), 32'd1);
        cw0 = cw_cnt;
        #1 reset = 1'b1;
        #1;
        chk("t5_mreq_drop", 32'(mem_req),  32'd0);
        chk("t5_busy_drop", 32'(cpu_busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_busy",  32'(cpu_busy),   32'd0);
        chk("t5_nocw",  32'(cw_cnt - cw0), 32'd0);
        chk("t5_hits",  32'(hit_count),  32'd0);
        chk("t5_miss",  32'(miss_count), 32'd0);

        // 6: saturation with cpu_req held across busy cycles
        mem_delay = 0;
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 4, "t6_miss", 1'b0);
        wait_done("t6m");
        cr0 = cr_cnt;
        for (int i = 0; i < 253; i++)
            issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 2, "t6_hit", 1'b1);
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 2, "t6_hit", 1'b0);
        wait_done("t6a");
        chk("t6_hits_fe", 32'(hit_count), 32'h0000_00FE);
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 2, "t6_hit", 1'b1);
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 2, "t6_hit", 1'b0);
        wait_done("t6b");
        chk("t6_hits_ff", 32'(hit_count), 32'h0000_00FF);
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h5A5A_0040, 2, "t6_sat", 1'b0);
        wait_done("t6c");
        chk("t6_hits_sat", 32'(hit_count), 32'h0000_00FF);
        chk("t6_accesses", 32'(cr_cnt - cr0), 32'd257);
        chk("t6_miss",     32'(miss_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
